mealy_seq_det: RTL

MEALY_SEQ_DET -- requirements
Module: mealy_seq_det

---
 rtl/mealy_seq_det_pkg.sv | 13 +
 rtl/mealy_seq_det_sat_counter.sv | 34 +++
 rtl/mealy_seq_det.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mealy_seq_det_pkg.sv
// Shared types and default sizes for the mealy_seq_det serial pattern detector.
package mealy_seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

    localparam int DEF_W     = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/mealy_seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mealy_seq_det.sv
// Mealy serial pattern detector with programmable pattern/length and saturating match counter.
// Define MEALY_SEQ_DET_OVERLAP_EN to keep the history after a match (overlapping detection).
module mealy_seq_det
    import mealy_seq_det_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_bit,
    input  logic                   pat_load,
    input  logic [W-1:0]           pat_in,
    input  logic [$clog2(W+1)-1:0] pat_len,
    input  logic                   cnt_clr,
    output logic                   match,
    output logic                   match_q,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   armed
);

    localparam int LW = $clog2(W+1);

    state_e        state_q, state_d;
    logic [W-1:0]  hist_q, hist_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] fill_q, fill_d;

    logic [W-1:0]  len_mask;
    logic [W-1:0]  hist_sh;
    logic [LW-1:0] fill_inc;
    logic [LW-1:0] load_len;
    logic          hit;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l > LW'(W)) begin
            return LW'(W);
        end
        return l;
    endfunction

    // Only the low LEN bits of the shifted history take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < W; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
    end

    assign hist_sh  = (hist_q << 1) | W'(in_bit);
    assign hit      = (((hist_sh ^ pat_q) & len_mask) == '0);
    assign fill_inc = fill_q + LW'(1);
    assign load_len = clamp_len(pat_len);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        match   = 1'b0;

        if (pat_load) begin
            pat_d  = pat_in;
            len_d  = load_len;
            hist_d = '0;
            fill_d = '0;
            if (load_len == '0) begin
                state_d = IDLE;
            end else if (load_len == LW'(1)) begin
                state_d = ARMED;
            end else begin
                state_d = FILL;
            end
        end else if (in_valid) begin
            unique case (state_q)
                FILL: begin
                    hist_d = hist_sh;
                    fill_d = fill_inc;
                    if (fill_inc == len_q - LW'(1)) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    hist_d = hist_sh;
                    if (hit) begin
                        match = 1'b1;
`ifdef MEALY_SEQ_DET_OVERLAP_EN
                        state_d = ARMED;
`else
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = (len_q == LW'(1)) ? ARMED : FILL;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            match_q <= match;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .Clk  (Clk),
        .reset(reset),
        .inc  (match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );

    assign armed = (state_q == ARMED);

endmodule
